// File: rtl/spi_bus_arbiter_if.sv
// Requester/engine-facing bus of the SPI arbiter.
// master: arbiter side. slave: requesters plus the SPI shift engine.
interface spi_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_tx_valid;
  logic [8*NUM_REQ-1:0] req_tx_data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   rx_valid;
  logic [7:0]           rx_data;
  logic [NUM_REQ-1:0]   cs_n;
  logic                 eng_start;
  logic [7:0]           eng_tx_data;
  logic                 eng_done;
  logic [7:0]           eng_rx_data;
  logic                 timeout_err;

  modport master (
    input  req, req_last, req_tx_valid, req_tx_data, eng_done, eng_rx_data,
    output gnt, tx_ready, rx_valid, rx_data, cs_n, eng_start, eng_tx_data, timeout_err
  );

  modport slave (
    output req, req_last, req_tx_valid, req_tx_data, eng_done, eng_rx_data,
    input  gnt, tx_ready, rx_valid, rx_data, cs_n, eng_start, eng_tx_data, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between NUM_REQ requesters.
// Owns chip selects, CS setup/hold timing and per-byte sequencing.
// Optional READY-state watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_bus_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
  logic               tx_ready_q, tx_ready_d;
  logic               eng_start_q, eng_start_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic [7:0]         eng_tx_data_q, eng_tx_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic               timeout_err_q, timeout_err_d;
`endif

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [31:0]        cand;
  logic               sel_req;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  // Round-robin pick: first requesting index at or above rr pointer, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && bus.req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Select the granted requester's handshake signals
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        sel_req   = bus.req[i];
        sel_valid = bus.req_tx_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_tx_data[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    cs_n_d        = cs_n_q;
    tx_ready_d    = tx_ready_q;
    rx_valid_d    = '0;
    rx_data_d     = rx_data_q;
    eng_start_d   = 1'b0;
    eng_tx_data_d = eng_tx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d          = ST_SETUP;
          g_d              = pick_idx;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          cs_n_d           = '1;
          cs_n_d[pick_idx] = 1'b0;
          cnt_d            = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d    = ST_READY;
          tx_ready_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (!sel_req) begin
          // requester withdrew: release without starting a byte
          state_d    = ST_HOLD;
          tx_ready_d = 1'b0;
          cnt_d      = '0;
        end else if (sel_valid) begin
          state_d       = ST_BUSY;
          tx_ready_d    = 1'b0;
          eng_start_d   = 1'b1;
          eng_tx_data_d = sel_data;
          last_d        = sel_last;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = ST_HOLD;
          tx_ready_d    = 1'b0;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_BUSY: begin
        if (bus.eng_done) begin
          rx_data_d  = bus.eng_rx_data;
          rx_valid_d = gnt_q;
          cnt_d      = '0;
          if (last_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d    = ST_READY;
            tx_ready_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cs_n_d  = '1;
          rr_d    = (32'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        cs_n_d     = '1;
        tx_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      g_q           <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      gnt_q         <= '0;
      cs_n_q        <= '1;
      tx_ready_q    <= 1'b0;
      rx_valid_q    <= '0;
      rx_data_q     <= '0;
      eng_start_q   <= 1'b0;
      eng_tx_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      cs_n_q        <= cs_n_d;
      tx_ready_q    <= tx_ready_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      eng_start_q   <= eng_start_d;
      eng_tx_data_q <= eng_tx_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_tx_data = eng_tx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
